// File: rtl/wbi_pkg.sv
// Purpose: shared widths, command/response beat types and helpers for the wishbone chain.
// Latency: n/a (types only).
// Backpressure: n/a.
package wbi_pkg;

    localparam int WBI_AW = 32;
    localparam int WBI_BW = 4;
    localparam int WBI_BL = 10;
    localparam int WBI_DW = 32;
    localparam int WBI_TW = 4;

    // One command beat as it travels down the chain.
    typedef struct packed {
        logic [WBI_AW-1:0] adr;
        logic              we;
        logic [WBI_DW-1:0] dat;
        logic [WBI_BW-1:0] sel;
        logic [WBI_TW-1:0] tid;
        logic [WBI_BL-1:0] bl;
    } wbi_cmd_t;

    // One response beat as it travels back up the chain.
    typedef struct packed {
        logic [WBI_DW-1:0] dat;
        logic              ack;
        logic              lack;
        logic              err;
        logic [WBI_TW-1:0] tid;
    } wbi_res_t;

    // Pointer wrap relies on the depth being a power of two.
    function automatic bit wbi_is_pow2_ge2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/wbi_stage_fifo_if.sv
// Purpose: one wishbone chain link, command channel downstream and response channel upstream.
// Latency: n/a (wires only).
// Backpressure: cmd_wrdy throttles commands, res_rrdy throttles responses.
interface wbi_stage_fifo_if;
    import wbi_pkg::*;

    logic              cmd_wval;
    logic              cmd_wrdy;
    logic [WBI_AW-1:0] cmd_adr;
    logic              cmd_we;
    logic [WBI_DW-1:0] cmd_dat;
    logic [WBI_BW-1:0] cmd_sel;
    logic [WBI_TW-1:0] cmd_tid;
    logic [WBI_BL-1:0] cmd_bl;

    logic              res_rval;
    logic              res_rrdy;
    logic [WBI_DW-1:0] res_dat;
    logic              res_ack;
    logic              res_lack;
    logic              res_err;
    logic [WBI_TW-1:0] res_tid;

    // Initiator side: issues commands, consumes responses.
    modport master (
        output cmd_wval, cmd_adr, cmd_we, cmd_dat, cmd_sel, cmd_tid, cmd_bl,
        input  cmd_wrdy,
        input  res_rval, res_dat, res_ack, res_lack, res_err, res_tid,
        output res_rrdy
    );

    // Target side: consumes commands, issues responses.
    modport slave (
        input  cmd_wval, cmd_adr, cmd_we, cmd_dat, cmd_sel, cmd_tid, cmd_bl,
        output cmd_wrdy,
        output res_rval, res_dat, res_ack, res_lack, res_err, res_tid,
        input  res_rrdy
    );

endinterface

// File: rtl/wbi_fifo_ch.sv
// Purpose: generic valid/ready FIFO channel with occupancy level and synchronous flush.
// Latency: 1 clk from push into an empty FIFO to out_vld; no bypass.
// Backpressure: in_rdy decoded from the level register only, never from out_rdy.
module wbi_fifo_ch #(
    parameter  int WD    = 8,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          mclk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [WD-1:0] in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [WD-1:0] out_dat,
    output logic [LW-1:0] level
);

    logic [WD-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          push;
    logic          pop;

    assign in_rdy  = (cnt != LW'(DEPTH));
    assign out_vld = (cnt != '0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign out_dat = mem[rd_ptr];
    assign level   = cnt;

    // Storage write; reset clears every entry so the head is never X.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; flush discards any push or pop in the same cycle.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy counter; push and pop together leave it unchanged.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wbi_stage_fifo.sv
// Purpose: staging buffer between previous-chain (wbp) and next-chain (wbd) ports, cmd + res FIFOs.
// Latency: 1 clk per channel, full throughput of 1 beat/clk.
// Backpressure: upstream ready comes from FIFO level registers only; no combinational path.
module wbi_stage_fifo
    import wbi_pkg::*;
#(
    parameter  int AW        = 32,
    parameter  int BW        = 4,
    parameter  int BL        = 10,
    parameter  int DW        = 32,
    parameter  int CMD_DEPTH = 2,
    parameter  int RES_DEPTH = 4,
    localparam int CLW       = $clog2(CMD_DEPTH) + 1,
    localparam int RLW       = $clog2(RES_DEPTH) + 1
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             flush_i,
    output logic [CLW-1:0]   cmd_level_o,
    output logic [RLW-1:0]   res_level_o,
    wbi_stage_fifo_if.slave  wbp,
    wbi_stage_fifo_if.master wbd
);

    // Elaboration-time sanity: depths must wrap cleanly and widths must match the shared types.
    if (!wbi_is_pow2_ge2(CMD_DEPTH)) begin : g_bad_cmd_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (!wbi_is_pow2_ge2(RES_DEPTH)) begin : g_bad_res_depth
        $error("RES_DEPTH must be a power of two and at least 2");
    end
    if (AW != WBI_AW || BW != WBI_BW || BL != WBI_BL || DW != WBI_DW) begin : g_bad_width
        $error("AW/BW/BL/DW must match the wbi_pkg beat types");
    end

    wbi_cmd_t cmd_in;
    wbi_cmd_t cmd_out;
    wbi_res_t res_in;
    wbi_res_t res_out;

    assign cmd_in = '{adr: wbp.cmd_adr, we: wbp.cmd_we, dat: wbp.cmd_dat,
                      sel: wbp.cmd_sel, tid: wbp.cmd_tid, bl: wbp.cmd_bl};

    assign wbd.cmd_adr = cmd_out.adr;
    assign wbd.cmd_we  = cmd_out.we;
    assign wbd.cmd_dat = cmd_out.dat;
    assign wbd.cmd_sel = cmd_out.sel;
    assign wbd.cmd_tid = cmd_out.tid;
    assign wbd.cmd_bl  = cmd_out.bl;

    assign res_in = '{dat: wbd.res_dat, ack: wbd.res_ack, lack: wbd.res_lack,
                      err: wbd.res_err, tid: wbd.res_tid};

    assign wbp.res_dat  = res_out.dat;
    assign wbp.res_ack  = res_out.ack;
    assign wbp.res_lack = res_out.lack;
    assign wbp.res_err  = res_out.err;
    assign wbp.res_tid  = res_out.tid;

    wbi_fifo_ch #(
        .WD    ($bits(wbi_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .mclk    (mclk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .in_vld  (wbp.cmd_wval),
        .in_rdy  (wbp.cmd_wrdy),
        .in_dat  (cmd_in),
        .out_vld (wbd.cmd_wval),
        .out_rdy (wbd.cmd_wrdy),
        .out_dat (cmd_out),
        .level   (cmd_level_o)
    );

    wbi_fifo_ch #(
        .WD    ($bits(wbi_res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .mclk    (mclk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .in_vld  (wbd.res_rval),
        .in_rdy  (wbd.res_rrdy),
        .in_dat  (res_in),
        .out_vld (wbp.res_rval),
        .out_rdy (wbp.res_rrdy),
        .out_dat (res_out),
        .level   (res_level_o)
    );

endmodule

// File: tb/tb_wbi_stage_fifo.sv
// Purpose: self-checking bench for wbi_stage_fifo against a queue-based reference model.
// Latency: model expects 1 clk push-to-valid per channel.
// Backpressure: model ready = queue not full, independent of downstream ready.
module tb_wbi_stage_fifo;
    import wbi_pkg::*;

    localparam int CD  = 2;
    localparam int RD  = 4;
    localparam int CLW = $clog2(CD) + 1;
    localparam int RLW = $clog2(RD) + 1;

    logic           mclk    = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush_i = 1'b0;
    logic [CLW-1:0] cmd_level_o;
    logic [RLW-1:0] res_level_o;

    int total = 0;
    int bad   = 0;

    wbi_cmd_t cq[$];
    wbi_res_t rq[$];
    bit       last_cpush;
    bit       last_rpush;

    wbi_stage_fifo_if wbp();
    wbi_stage_fifo_if wbd();

    wbi_stage_fifo #(
        .CMD_DEPTH (CD),
        .RES_DEPTH (RD)
    ) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .flush_i     (flush_i),
        .cmd_level_o (cmd_level_o),
        .res_level_o (res_level_o),
        .wbp         (wbp.slave),
        .wbd         (wbd.master)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wbi_cmd_t cmd_drv();
        wbi_cmd_t c;
        c.adr = wbp.cmd_adr; c.we = wbp.cmd_we; c.dat = wbp.cmd_dat;
        c.sel = wbp.cmd_sel; c.tid = wbp.cmd_tid; c.bl = wbp.cmd_bl;
        return c;
    endfunction

    function automatic wbi_cmd_t cmd_obs();
        wbi_cmd_t c;
        c.adr = wbd.cmd_adr; c.we = wbd.cmd_we; c.dat = wbd.cmd_dat;
        c.sel = wbd.cmd_sel; c.tid = wbd.cmd_tid; c.bl = wbd.cmd_bl;
        return c;
    endfunction

    function automatic wbi_res_t res_drv();
        wbi_res_t r;
        r.dat = wbd.res_dat; r.ack = wbd.res_ack; r.lack = wbd.res_lack;
        r.err = wbd.res_err; r.tid = wbd.res_tid;
        return r;
    endfunction

    function automatic wbi_res_t res_obs();
        wbi_res_t r;
        r.dat = wbp.res_dat; r.ack = wbp.res_ack; r.lack = wbp.res_lack;
        r.err = wbp.res_err; r.tid = wbp.res_tid;
        return r;
    endfunction

    task automatic set_cmd(input bit v, input logic [31:0] adr, input logic [3:0] tid);
        wbp.cmd_wval = v;
        wbp.cmd_adr  = adr;
        wbp.cmd_we   = tid[0];
        wbp.cmd_dat  = ~adr;
        wbp.cmd_sel  = tid;
        wbp.cmd_tid  = tid;
        wbp.cmd_bl   = adr[9:0];
    endtask

    task automatic set_res(input bit v, input logic [3:0] tid);
        wbd.res_rval = v;
        wbd.res_dat  = 32'hC0DE_0000 | 32'(tid);
        wbd.res_ack  = 1'b1;
        wbd.res_lack = tid[0];
        wbd.res_err  = (tid == 4'hF);
        wbd.res_tid  = tid;
    endtask

    task automatic rand_inputs();
        wbp.cmd_wval = ($urandom_range(0, 9) < 7);
        wbp.cmd_adr  = $urandom;
        wbp.cmd_we   = 1'($urandom);
        wbp.cmd_dat  = $urandom;
        wbp.cmd_sel  = 4'($urandom);
        wbp.cmd_tid  = 4'($urandom);
        wbp.cmd_bl   = 10'($urandom);
        wbd.cmd_wrdy = ($urandom_range(0, 3) != 0);
        wbd.res_rval = ($urandom_range(0, 9) < 6);
        wbd.res_dat  = $urandom;
        wbd.res_ack  = 1'($urandom);
        wbd.res_lack = 1'($urandom);
        wbd.res_err  = 1'($urandom);
        wbd.res_tid  = 4'($urandom);
        wbp.res_rrdy = ($urandom_range(0, 3) != 0);
    endtask

    // Outputs expected while reset is (or has just been) asserted.
    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wval"},  128'(wbd.cmd_wval), 128'(0));
        chk({tag, "_wrdy"},  128'(wbp.cmd_wrdy), 128'(1));
        chk({tag, "_rval"},  128'(wbp.res_rval), 128'(0));
        chk({tag, "_rrdy"},  128'(wbd.res_rrdy), 128'(1));
        chk({tag, "_clvl"},  128'(cmd_level_o),  128'(0));
        chk({tag, "_rlvl"},  128'(res_level_o),  128'(0));
        chk({tag, "_cdat"},  128'(cmd_obs()),    128'(0));
        chk({tag, "_rdat"},  128'(res_obs()),    128'(0));
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic step();
        bit       cpush, cpop, rpush, rpop, fl;
        wbi_cmd_t cin;
        wbi_res_t rin;
        @(negedge mclk);
        chk("cmd_wval",  128'(wbd.cmd_wval), 128'(cq.size() != 0));
        chk("cmd_wrdy",  128'(wbp.cmd_wrdy), 128'(cq.size() != CD));
        chk("cmd_level", 128'(cmd_level_o),  128'(cq.size()));
        if (cq.size() != 0) chk("cmd_head", 128'(cmd_obs()), 128'(cq[0]));
        chk("res_rval",  128'(wbp.res_rval), 128'(rq.size() != 0));
        chk("res_rrdy",  128'(wbd.res_rrdy), 128'(rq.size() != RD));
        chk("res_level", 128'(res_level_o),  128'(rq.size()));
        if (rq.size() != 0) chk("res_head", 128'(res_obs()), 128'(rq[0]));
        cin   = cmd_drv();
        rin   = res_drv();
        fl    = flush_i;
        cpush = wbp.cmd_wval && (cq.size() != CD);
        cpop  = (cq.size() != 0) && wbd.cmd_wrdy;
        rpush = wbd.res_rval && (rq.size() != RD);
        rpop  = (rq.size() != 0) && wbp.res_rrdy;
        last_cpush = cpush && !fl;
        last_rpush = rpush && !fl;
        @(posedge mclk);
        if (fl) begin
            cq.delete();
            rq.delete();
        end else begin
            if (cpop)  void'(cq.pop_front());
            if (cpush) cq.push_back(cin);
            if (rpop)  void'(rq.pop_front());
            if (rpush) rq.push_back(rin);
        end
        #1;
    endtask

    initial begin
        int k;

        // 1: reset held while inputs toggle.
        for (int c = 0; c < 4; c++) begin
            @(posedge mclk);
            #1 rand_inputs();
            @(negedge mclk);
            chk_reset_outs("rst");
        end
        set_cmd(0, 0, 0);
        set_res(0, 0);
        wbd.cmd_wrdy = 1'b0;
        wbp.res_rrdy = 1'b0;
        @(negedge mclk);
        #2 reset_n = 1'b1;
        @(posedge mclk);
        #1;

        // 2: stream 16 commands with downstream always ready.
        wbd.cmd_wrdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_cmd(1, 32'h100 + 32'(4 * i), 4'(i));
            step();
        end
        set_cmd(0, 0, 0);
        repeat (2) step();

        // 3/4: stall with downstream not ready, then release while pushing.
        wbd.cmd_wrdy = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            set_cmd(k < 3, 32'h200 + 32'(4 * k), 4'(k));
            step();
            if (last_cpush) k++;
        end
        chk("stall_accepted", 128'(k), 128'(2));
        wbd.cmd_wrdy = 1'b1;
        for (int c = 0; c < 10 && k < 3; c++) begin
            set_cmd(1, 32'h200 + 32'(4 * k), 4'(k));
            step();
            if (last_cpush) k++;
        end
        chk("all_beats_in", 128'(k), 128'(3));
        set_cmd(0, 0, 0);
        repeat (3) step();

        // 5: fill the response FIFO, then pop and push together.
        wbp.res_rrdy = 1'b0;
        for (int t = 0; t < 4; t++) begin
            set_res(1, 4'(t));
            step();
        end
        wbp.res_rrdy = 1'b1;
        k = 0;
        for (int c = 0; c < 10 && k == 0; c++) begin
            set_res(1, 4'd4);
            step();
            if (last_rpush) k = 1;
        end
        chk("res_tid4_in", 128'(k), 128'(1));
        set_res(0, 0);
        repeat (6) step();

        // 6: flush with three responses queued and a concurrent push.
        wbp.res_rrdy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            set_res(1, 4'(t));
            step();
        end
        flush_i = 1'b1;
        set_res(1, 4'd9);
        step();
        flush_i = 1'b0;
        set_res(0, 0);
        wbp.res_rrdy = 1'b1;
        repeat (3) step();

        // 7: async reset with two commands queued, then a fresh command.
        wbd.cmd_wrdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            set_cmd(1, 32'h300 + 32'(4 * t), 4'(t));
            step();
        end
        set_cmd(1, 32'h308, 4'd2);
        #2 reset_n = 1'b0;
        #1 chk_reset_outs("arst");
        cq.delete();
        rq.delete();
        set_cmd(0, 0, 0);
        set_res(0, 0);
        @(negedge mclk);
        #2 reset_n = 1'b1;
        @(posedge mclk);
        #1;
        wbd.cmd_wrdy = 1'b1;
        set_cmd(1, 32'h500, 4'd5);
        step();
        set_cmd(0, 0, 0);
        @(negedge mclk);
        chk("post_rst_tid", 128'(wbd.cmd_tid), 128'(5));
        @(posedge mclk);
        #1;
        cq.delete();
        repeat (2) step();

        // Randomised traffic on both channels with occasional flush.
        for (int c = 0; c < 800; c++) begin
            rand_inputs();
            flush_i = ($urandom_range(0, 39) == 0);
            step();
        end
        flush_i = 1'b0;
        set_cmd(0, 0, 0);
        set_res(0, 0);
        wbd.cmd_wrdy = 1'b1;
        wbp.res_rrdy = 1'b1;
        repeat (6) step();
        chk("drain_clvl", 128'(cmd_level_o), 128'(0));
        chk("drain_rlvl", 128'(res_level_o), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
